// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - two-requester round-robin front end for a 1R1W register file with clear sequencer
module regfile_port_arbiter #(
    parameter int width = 32,
    parameter int n     = 5,
    parameter int size  = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    input  logic             REQ0_WRITE,
    input  logic [n-1:0]     REQ0_INDEX,
    input  logic [width-1:0] REQ0_DATA,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic             REQ1_WRITE,
    input  logic [n-1:0]     REQ1_INDEX,
    input  logic [width-1:0] REQ1_DATA,
    output logic             REQ1_READY,
    output logic             RESP0_VALID,
    output logic [width-1:0] RESP0_DATA,
    output logic             RESP1_VALID,
    output logic [width-1:0] RESP1_DATA,
    output logic [n-1:0]     RF_READ_INDEX,
    input  logic [width-1:0] RF_READ_DATA,
    output logic             RF_WRITE_EN,
    output logic [n-1:0]     RF_WRITE_INDEX,
    output logic [width-1:0] RF_WRITE_DATA,
    input  logic             CLEAR,
    output logic             CLEAR_DONE
);

    localparam logic ST_CLR   = 1'b0;
    localparam logic ST_SERVE = 1'b1;

    localparam logic [n:0]   size_lim = (n+1)'(size);
    localparam logic [n-1:0] last_idx = n'(size - 1);

    logic             state;
    logic [n-1:0]     cnt;
    logic             rr;
    logic             resp0_v, resp1_v;
    logic [width-1:0] resp0_d, resp1_d;

    logic             arb, grant0, grant1, any_grant;
    logic             sel_write, in_range;
    logic [n-1:0]     sel_index;
    logic [width-1:0] sel_data;

    // Grants are withheld whenever reset is high or a clear is being requested.
    always_comb begin
        arb       = (state == ST_SERVE) && !RST && !CLEAR;
        grant0    = arb && REQ0_VALID && (!REQ1_VALID || !rr);
        grant1    = arb && REQ1_VALID && (!REQ0_VALID || rr);
        any_grant = grant0 || grant1;
        sel_write = grant0 ? REQ0_WRITE : REQ1_WRITE;
        sel_index = grant0 ? REQ0_INDEX : REQ1_INDEX;
        sel_data  = grant0 ? REQ0_DATA  : REQ1_DATA;
        in_range  = {1'b0, sel_index} < size_lim;
    end

    always_comb begin
        RF_READ_INDEX  = '0;
        RF_WRITE_EN    = 1'b0;
        RF_WRITE_INDEX = '0;
        RF_WRITE_DATA  = '0;
        if (state == ST_CLR && !RST) begin
            RF_WRITE_EN    = 1'b1;
            RF_WRITE_INDEX = cnt;
        end else if (any_grant && sel_write) begin
            RF_WRITE_EN    = in_range;
            RF_WRITE_INDEX = in_range ? sel_index : '0;
            RF_WRITE_DATA  = in_range ? sel_data : '0;
        end else if (any_grant) begin
            RF_READ_INDEX = sel_index;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_CLR;
            cnt     <= '0;
            rr      <= 1'b0;
            resp0_v <= 1'b0;
            resp1_v <= 1'b0;
            resp0_d <= '0;
            resp1_d <= '0;
        end else begin
            resp0_v <= grant0 && !REQ0_WRITE;
            resp1_v <= grant1 && !REQ1_WRITE;
            if (grant0 && !REQ0_WRITE)
                resp0_d <= in_range ? RF_READ_DATA : '0;
            if (grant1 && !REQ1_WRITE)
                resp1_d <= in_range ? RF_READ_DATA : '0;
            if (any_grant)
                rr <= grant0;
            if (state == ST_CLR) begin
                if (cnt == last_idx) begin
                    state <= ST_SERVE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (CLEAR) begin
                state <= ST_CLR;
                cnt   <= '0;
            end
        end
    end

    assign REQ0_READY  = grant0;
    assign REQ1_READY  = grant1;
    assign RESP0_VALID = resp0_v;
    assign RESP1_VALID = resp1_v;
    assign RESP0_DATA  = resp0_d;
    assign RESP1_DATA  = resp1_d;
    assign CLEAR_DONE  = (state == ST_SERVE);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - self-checking bench for regfile_port_arbiter
module tb_regfile_port_arbiter;
    localparam int W = 32;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst, clear, preload;
    logic v0, w0, v1, w1;
    logic [N-1:0] i0, i1;
    logic [W-1:0] d0, d1;

    logic rdy0, rdy1, rv0, rv1, we, done;
    logic [W-1:0] rd0, rd1, rf_rdata, wdata;
    logic [N-1:0] ridx, widx;

    logic rdy0_b, rdy1_b, rv0_b, rv1_b, we_b, done_b;
    logic [W-1:0] rd0_b, rd1_b, rf_rdata_b, wdata_b;
    logic [N-1:0] ridx_b, widx_b;

    logic [W-1:0] rf [32];
    logic [W-1:0] rf_b [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter #(.width(W), .n(N), .size(32)) dut (
        .CLK(clk), .RST(rst),
        .REQ0_VALID(v0), .REQ0_WRITE(w0), .REQ0_INDEX(i0), .REQ0_DATA(d0), .REQ0_READY(rdy0),
        .REQ1_VALID(v1), .REQ1_WRITE(w1), .REQ1_INDEX(i1), .REQ1_DATA(d1), .REQ1_READY(rdy1),
        .RESP0_VALID(rv0), .RESP0_DATA(rd0), .RESP1_VALID(rv1), .RESP1_DATA(rd1),
        .RF_READ_INDEX(ridx), .RF_READ_DATA(rf_rdata),
        .RF_WRITE_EN(we), .RF_WRITE_INDEX(widx), .RF_WRITE_DATA(wdata),
        .CLEAR(clear), .CLEAR_DONE(done)
    );

    regfile_port_arbiter #(.width(W), .n(N), .size(20)) dut_b (
        .CLK(clk), .RST(rst),
        .REQ0_VALID(v0), .REQ0_WRITE(w0), .REQ0_INDEX(i0), .REQ0_DATA(d0), .REQ0_READY(rdy0_b),
        .REQ1_VALID(v1), .REQ1_WRITE(w1), .REQ1_INDEX(i1), .REQ1_DATA(d1), .REQ1_READY(rdy1_b),
        .RESP0_VALID(rv0_b), .RESP0_DATA(rd0_b), .RESP1_VALID(rv1_b), .RESP1_DATA(rd1_b),
        .RF_READ_INDEX(ridx_b), .RF_READ_DATA(rf_rdata_b),
        .RF_WRITE_EN(we_b), .RF_WRITE_INDEX(widx_b), .RF_WRITE_DATA(wdata_b),
        .CLEAR(clear), .CLEAR_DONE(done_b)
    );

    // Register file arrays: combinational read, clocked write.
    assign rf_rdata   = rf[ridx];
    assign rf_rdata_b = rf_b[ridx_b];

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) begin
                rf[k]   <= 32'hA5A5_0000 | 32'(k);
                rf_b[k] <= 32'h5A5A_0000 | 32'(k);
            end
        end else begin
            if (we)   rf[widx]     <= wdata;
            if (we_b) rf_b[widx_b] <= wdata_b;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        v0 = 0; w0 = 0; i0 = '0; d0 = '0;
        v1 = 0; w1 = 0; i1 = '0; d1 = '0;
        clear = 0;
    endtask

    task automatic test_reset;
        rst = 1; preload = 1; idle();
        v0 = 1; v1 = 1;
        tick();
        preload = 0;
        tick();
        #1;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%0b exp=0", rdy0); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%0b exp=0", rdy1); end
        checks++; if (rv0 !== 1'b0 || rv1 !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0b%0b exp=00", rv0, rv1); end
        checks++; if (rd0 !== '0 || rd1 !== '0) begin errors++; $display("FAIL reset_resp_data got=%0h/%0h exp=0/0", rd0, rd1); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_clear_done got=%0b exp=0", done); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_write_en got=%0b exp=0", we); end
    endtask

    task automatic test_reset_clear;
        int nz;
        v0 = 1; i0 = 5'd3; v1 = 1; i1 = 5'd4;
        rst = 0;
        for (int k = 0; k < 32; k++) begin
            #1;
            checks++; if (we !== 1'b1 || widx !== 5'(k) || wdata !== '0) begin errors++; $display("FAIL rclr_write[%0d] got en=%0b idx=%0d data=%0h exp en=1 idx=%0d data=0", k, we, widx, wdata, k); end
            checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rclr_idle[%0d] got rdy=%0b%0b done=%0b exp 00/0", k, rdy0, rdy1, done); end
            tick();
        end
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rclr_done got=%0b exp=1", done); end
        nz = 0;
        for (int k = 0; k < 32; k++) if (rf[k] !== '0) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL rclr_zeroed got=%0d nonzero exp=0", nz); end
        idle(); v0 = 1; i0 = 5'd7;
        #1;
        checks++; if (rdy0 !== 1'b1 || ridx !== 5'd7) begin errors++; $display("FAIL rclr_read_grant got rdy=%0b idx=%0d exp 1/7", rdy0, ridx); end
        tick();
        checks++; if (rv0 !== 1'b1 || rd0 !== '0) begin errors++; $display("FAIL rclr_read7 got v=%0b d=%0h exp 1/0", rv0, rd0); end
        idle();
    endtask

    task automatic test_write_read;
        idle(); v0 = 1; w0 = 1; i0 = 5'd5; d0 = 32'hDEADBEEF;
        #1;
        checks++; if (rdy0 !== 1'b1 || rdy1 !== 1'b0) begin errors++; $display("FAIL wr_grant got=%0b%0b exp=10", rdy0, rdy1); end
        checks++; if (we !== 1'b1 || widx !== 5'd5 || wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_port got en=%0b idx=%0d d=%0h exp 1/5/deadbeef", we, widx, wdata); end
        tick();
        idle(); v1 = 1; i1 = 5'd5;
        #1;
        checks++; if (rdy1 !== 1'b1 || ridx !== 5'd5) begin errors++; $display("FAIL rd_grant got rdy=%0b idx=%0d exp 1/5", rdy1, ridx); end
        tick();
        idle();
        checks++; if (rv1 !== 1'b1 || rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_resp got v=%0b d=%0h exp 1/deadbeef", rv1, rd1); end
        checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL rd_resp0_quiet got=%0b exp=0", rv0); end
        tick();
        checks++; if (rv1 !== 1'b0 || rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got v=%0b d=%0h exp 0/deadbeef", rv1, rd1); end
    endtask

    task automatic test_contention;
        logic [W-1:0] val1, val2;
        val1 = $urandom | 32'h1;
        val2 = $urandom | 32'h1;
        idle(); v0 = 1; w0 = 1; i0 = 5'd1; d0 = val1;
        tick();
        idle(); v1 = 1; w1 = 1; i1 = 5'd2; d1 = val2;
        tick();
        idle(); v0 = 1; i0 = 5'd1; v1 = 1; i1 = 5'd2;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (rdy0 !== (c % 2 == 0) || rdy1 !== (c % 2 == 1)) begin errors++; $display("FAIL cont_grant[%0d] got=%0b%0b exp req%0d", c, rdy0, rdy1, c % 2); end
            tick();
            checks++; if (rv0 !== (c % 2 == 0) || rv1 !== (c % 2 == 1)) begin errors++; $display("FAIL cont_resp[%0d] got=%0b%0b exp req%0d", c, rv0, rv1, c % 2); end
            checks++; if ((c % 2 == 0) ? (rd0 !== val1) : (rd1 !== val2)) begin errors++; $display("FAIL cont_data[%0d] got=%0h/%0h exp=%0h/%0h", c, rd0, rd1, val1, val2); end
        end
        idle();
    endtask

    task automatic test_out_of_range;
        idle(); v0 = 1; w0 = 1; i0 = 5'd25; d0 = 32'h12345678;
        #1;
        checks++; if (rdy0_b !== 1'b1 || rdy1_b !== 1'b0) begin errors++; $display("FAIL oor_wr_handshake got=%0b%0b exp=10", rdy0_b, rdy1_b); end
        checks++; if (we_b !== 1'b0) begin errors++; $display("FAIL oor_wr_suppress got=%0b exp=0", we_b); end
        tick();
        idle(); v0 = 1; i0 = 5'd25;
        #1;
        checks++; if (rdy0_b !== 1'b1) begin errors++; $display("FAIL oor_rd_handshake got=%0b exp=1", rdy0_b); end
        tick();
        idle();
        checks++; if (rv0_b !== 1'b1 || rd0_b !== '0) begin errors++; $display("FAIL oor_rd_zero got v=%0b d=%0h exp 1/0", rv0_b, rd0_b); end
        checks++; if (rf_b[25] !== 32'h5A5A0019) begin errors++; $display("FAIL oor_array_untouched got=%0h exp=5a5a0019", rf_b[25]); end
        checks++; if (rv0 !== 1'b1 || rd0 !== 32'h12345678) begin errors++; $display("FAIL inrange_rd got v=%0b d=%0h exp 1/12345678", rv0, rd0); end
        checks++; if (done_b !== 1'b1 || rv1_b !== 1'b0) begin errors++; $display("FAIL oor_state got done=%0b rv1=%0b exp 1/0", done_b, rv1_b); end
    endtask

    task automatic test_clear_traffic;
        int nz;
        idle(); v0 = 1; i0 = 5'd5;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL clr_pre_grant got=%0b exp=1", rdy0); end
        tick();
        clear = 1; v0 = 1; i0 = 5'd1; v1 = 1; i1 = 5'd2;
        #1;
        checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL clr_block got=%0b%0b exp=00", rdy0, rdy1); end
        checks++; if (rv0 !== 1'b1 || rd0 !== 32'hDEADBEEF || done !== 1'b1) begin errors++; $display("FAIL clr_pending_resp got v=%0b d=%0h done=%0b exp 1/deadbeef/1", rv0, rd0, done); end
        tick();
        clear = 0;
        for (int k = 0; k < 32; k++) begin
            #1;
            checks++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0 || done !== 1'b0 || rv0 !== 1'b0) begin errors++; $display("FAIL clr_quiet[%0d] got rdy=%0b%0b done=%0b rv0=%0b exp 00/0/0", k, rdy0, rdy1, done, rv0); end
            checks++; if (we !== 1'b1 || widx !== 5'(k) || wdata !== '0) begin errors++; $display("FAIL clr_write[%0d] got en=%0b idx=%0d exp 1/%0d", k, we, widx, k); end
            tick();
        end
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clr_done got=%0b exp=1", done); end
        nz = 0;
        for (int k = 0; k < 32; k++) if (rf[k] !== '0) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL clr_zeroed got=%0d nonzero exp=0", nz); end
        idle();
    endtask

    task automatic test_random;
        logic [W-1:0] mem_m [32];
        int last_grant;
        logic g0, g1, er0, er1;
        logic [W-1:0] ed0, ed1;
        for (int k = 0; k < 32; k++) mem_m[k] = '0;
        idle(); v0 = 1; i0 = 5'd0;
        tick();
        last_grant = 0;
        for (int c = 0; c < 300; c++) begin
            v0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
            i0 = 5'($urandom_range(0, 31)); d0 = $urandom;
            v1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            i1 = 5'($urandom_range(0, 31)); d1 = $urandom;
            #1;
            // Under contention the requester that did not win last time goes first.
            g0 = v0 && (!v1 || last_grant == 1);
            g1 = v1 && !g0;
            checks++; if (rdy0 !== g0 || rdy1 !== g1) begin errors++; $display("FAIL rnd_grant[%0d] got=%0b%0b exp=%0b%0b", c, rdy0, rdy1, g0, g1); end
            checks++; if (we !== ((g0 && w0) || (g1 && w1))) begin errors++; $display("FAIL rnd_we[%0d] got=%0b", c, we); end
            if (g0 && w0) begin
                checks++; if (widx !== i0 || wdata !== d0) begin errors++; $display("FAIL rnd_wport0[%0d] got %0d/%0h exp %0d/%0h", c, widx, wdata, i0, d0); end
            end
            if (g1 && w1) begin
                checks++; if (widx !== i1 || wdata !== d1) begin errors++; $display("FAIL rnd_wport1[%0d] got %0d/%0h exp %0d/%0h", c, widx, wdata, i1, d1); end
            end
            er0 = g0 && !w0; ed0 = mem_m[i0];
            er1 = g1 && !w1; ed1 = mem_m[i1];
            tick();
            checks++; if (rv0 !== er0 || rv1 !== er1) begin errors++; $display("FAIL rnd_resp_valid[%0d] got=%0b%0b exp=%0b%0b", c, rv0, rv1, er0, er1); end
            if (er0) begin
                checks++; if (rd0 !== ed0) begin errors++; $display("FAIL rnd_resp0[%0d] got=%0h exp=%0h", c, rd0, ed0); end
            end
            if (er1) begin
                checks++; if (rd1 !== ed1) begin errors++; $display("FAIL rnd_resp1[%0d] got=%0h exp=%0h", c, rd1, ed1); end
            end
            if (g0 && w0) mem_m[i0] = d0;
            if (g1 && w1) mem_m[i1] = d1;
            if (g0) last_grant = 0;
            else if (g1) last_grant = 1;
        end
        idle();
    endtask

    task automatic test_reset_mid_clear;
        idle(); clear = 1;
        tick();
        clear = 0;
        repeat (10) tick();
        #1;
        checks++; if (we !== 1'b1 || widx !== 5'd10) begin errors++; $display("FAIL mid_counter got en=%0b idx=%0d exp 1/10", we, widx); end
        rst = 1; v0 = 1; i0 = 5'd3;
        #1;
        checks++; if (rdy0 !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL mid_rst_dominates got rdy=%0b we=%0b exp 0/0", rdy0, we); end
        tick();
        rst = 0;
        for (int k = 0; k < 32; k++) begin
            #1;
            checks++; if (we !== 1'b1 || widx !== 5'(k) || rv0 !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_restart[%0d] got en=%0b idx=%0d rv0=%0b done=%0b exp 1/%0d/0/0", k, we, widx, rv0, done, k); end
            tick();
        end
        #1;
        checks++; if (done !== 1'b1 || rdy0 !== 1'b1 || rv0 !== 1'b0) begin errors++; $display("FAIL mid_done got done=%0b rdy0=%0b rv0=%0b exp 1/1/0", done, rdy0, rv0); end
        tick();
        checks++; if (rv0 !== 1'b1 || rd0 !== '0) begin errors++; $display("FAIL mid_read got v=%0b d=%0h exp 1/0", rv0, rd0); end
        idle();
    endtask

    initial begin
        test_reset();
        test_reset_clear();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_clear_traffic();
        test_random();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares one single-read/single-write register file between two requesters. Round-robin arbitration grants at most one read or write per cycle. A built-in clear sequencer zeroes every entry after reset or on command. Sits between the pipeline clients and a `mkRegFileVerilogLoadNormal`-style array, driving its combinational read port and its clocked write port.

## Interface
- `width`, 32, data bits per entry
- `n`, 5, index bits
- `size`, 32, number of entries (≤ 2^n)

- `CLK` in 1: clock
- `RST` in 1: synchronous reset, active-high
- `REQ0_VALID` / `REQ1_VALID` in 1: requester i has an operation
- `REQ0_WRITE` / `REQ1_WRITE` in 1: 1 = write, 0 = read
- `REQ0_INDEX` / `REQ1_INDEX` in n: entry index
- `REQ0_DATA` / `REQ1_DATA` in width: write data; ignored for reads
- `REQ0_READY` / `REQ1_READY` out 1: grant; the operation is accepted when VALID && READY
- `RESP0_VALID` / `RESP1_VALID` out 1: read data valid, one-cycle pulse
- `RESP0_DATA` / `RESP1_DATA` out width: read data
- `RF_READ_INDEX` out n: to regfile read address
- `RF_READ_DATA` in width: combinational regfile read data
- `RF_WRITE_EN` out 1: regfile write enable
- `RF_WRITE_INDEX` out n: regfile write address
- `RF_WRITE_DATA` out width: regfile write data
- `CLEAR` in 1: request full clear (level, sampled in SERVE)
- `CLEAR_DONE` out 1: high when in SERVE

## Operation
- States: CLR (clearing), SERVE.
- **Reset:**
  - State CLR, clear counter 0, round-robin pointer `rr`=0.
  - All RESP_VALID/RESP_DATA/READY = 0, CLEAR_DONE=0.
- **CLR:**
  - Each cycle drives RF_WRITE_EN=1, RF_WRITE_INDEX=counter, RF_WRITE_DATA=0, then increments the counter.
  - When the counter = size-1, the next state is SERVE.
  - READY0/READY1=0 throughout.
  - CLEAR is ignored; a clear in progress does not restart.
- **SERVE arbitration:**
  - One valid requester: it is granted.
  - Both valid: requester `rr` is granted.
  - After any grant, `rr` ← other requester. With no grant, `rr` holds.
  - READY is combinational from VALID and state. READY never asserts without VALID.
- **Granted write:**
  - RF_WRITE_EN=1, RF_WRITE_INDEX=REQ_INDEX, RF_WRITE_DATA=REQ_DATA in the same cycle.
  - Suppressed (RF_WRITE_EN=0, still handshaken) if INDEX ≥ size.
- **Granted read:**
  - RF_READ_INDEX=REQ_INDEX.
  - RF_READ_DATA is registered into RESP_DATA of that requester. RESP_VALID=1 next cycle only.
  - INDEX ≥ size returns 0.
  - RESP_DATA holds its last value when RESP_VALID=0.
- **Defaults when idle:** RF_READ_INDEX=0, RF_WRITE_EN=0.
- **CLEAR in SERVE:**
  - CLEAR=1 takes priority over requests: no grant that cycle, next state CLR with counter 0.
  - A read granted the previous cycle still delivers its RESP_VALID pulse.

## Timing
- Write: accepted at edge k, visible to a read granted at cycle k+1.
- Read latency: grant at cycle k → RESP_VALID and RESP_DATA at cycle k+1.
- Throughput: one operation per cycle total; each requester gets ≥ 1 grant per 2 cycles under contention.
- Clear duration:
  - Exactly `size` cycles of CLR.
  - After RST falls at edge e, CLEAR_DONE rises in cycle e+size.
  - After CLEAR is sampled at edge c, CLEAR_DONE=0 from c+1 and rises at c+1+size.
- RST high mid-clear or mid-read: restart CLR from 0, drop any pending RESP_VALID.
- RST dominates CLEAR and all requests.

## Test plan
- **Reset clear:** preload the regfile with nonzero data, pulse RST 1 cycle.
  - RF_WRITE_EN high for 32 cycles, indices 0..31, data 0.
  - CLEAR_DONE rises after cycle 32.
  - A later read of index 7 returns 0.
- **Write then read:**
  - Req0 writes 0xDEADBEEF to index 5; the next cycle req1 reads index 5.
  - RESP1_VALID pulses one cycle later with 0xDEADBEEF; RESP0_VALID stays 0.
- **Contention:** both requesters hold VALID reads of indices 1 and 2 for 4 cycles from `rr`=0.
  - Grants go 0,1,0,1.
  - Each RESP pulses on alternate cycles with the correct data.
- **Out of range:** size=20, write index 25 then read index 25.
  - The write is handshaken but RF_WRITE_EN=0.
  - The read returns RESP_DATA=0.
- **CLEAR during traffic:** read granted at cycle k, CLEAR=1 at cycle k+1 with both VALID.
  - RESP pulses at k+1; no grants for 32 cycles.
  - All entries are zero afterward.
- **Reset mid-clear:** RST asserted at CLR counter 10.
  - The counter restarts at 0.
  - CLEAR_DONE rises 32 cycles after RST falls.
  - No RESP_VALID is emitted.
